// File: rtl/cache_tag_array.sv
// Set-associative tag array with per-set valid bits and tree-PLRU replacement.
// Lookups respond one cycle after acceptance; a reset or flush_req sweeps one set per cycle.
module cache_tag_array #(
  parameter  int WAYS     = 4,
  parameter  int ADDR_W   = 26,
  parameter  int INDEX_W  = 9,
  parameter  int OFFSET_W = 4,
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
  localparam int WAYW     = $clog2(WAYS)
) (
  input  logic              main_clk,
  input  logic              main_reset,
  input  logic              flush_req,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [WAYW-1:0]   rsp_way,
  output logic              rsp_victim_valid,
  output logic [TAG_W-1:0]  rsp_victim_tag,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [WAYW-1:0]   fill_way,
  input  logic              inval_en,
  input  logic [ADDR_W-1:0] inval_addr,
  input  logic [WAYW-1:0]   inval_way,
  output logic              busy
);
  localparam int SETS = 1 << INDEX_W;
  localparam int TSB  = INDEX_W + OFFSET_W;

  typedef enum logic {S_FLUSH, S_IDLE} state_t;

  // Bit n set means the left subtree under heap node n was touched last.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAYW-1:0] way);
    logic [WAYS-2:0] b;
    int node;
    b = bits;
    node = 0;
    for (int l = 0; l < WAYW; l++) begin
      b[node] = ~way[WAYW-1-l];
      node = 2 * node + 1 + int'(way[WAYW-1-l]);
    end
    return b;
  endfunction

  function automatic logic [WAYW-1:0] plru_victim(input logic [WAYS-2:0] bits);
    int node;
    node = 0;
    for (int l = 0; l < WAYW; l++) node = 2 * node + 1 + int'(bits[node]);
    return WAYW'(node - (WAYS - 1));
  endfunction

  state_t                     state_q, state_d;
  logic [INDEX_W-1:0]         cnt_q, cnt_d;
  logic [WAYS-1:0]            valid_q [SETS];
  logic [WAYS-2:0]            plru_q  [SETS];

  logic [TAG_W-1:0]           req_tag, fill_tag;
  logic [INDEX_W-1:0]         req_idx, fill_idx, inval_idx;
  logic                       req_fire, fill_wr, inval_wr, flushing;

  logic                       vld_p1;
  logic [TAG_W-1:0]           tag_p1;
  logic [INDEX_W-1:0]         idx_p1;
  logic [WAYS-1:0][TAG_W-1:0] tag_rd_p1;

  logic [WAYS-1:0]            vset;
  logic [WAYS-2:0]            pset, fill_base;
  logic                       hit, inv_any, hit_upd;
  logic [WAYW-1:0]            hit_way, inv_way, sel_way;

  // Offset bits and the invalidate tag play no part in set selection.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[OFFSET_W-1:0], fill_addr[OFFSET_W-1:0],
                              inval_addr[OFFSET_W-1:0], inval_addr[ADDR_W-1:TSB]};

  assign req_tag   = req_addr[ADDR_W-1:TSB];
  assign req_idx   = req_addr[TSB-1:OFFSET_W];
  assign fill_tag  = fill_addr[ADDR_W-1:TSB];
  assign fill_idx  = fill_addr[TSB-1:OFFSET_W];
  assign inval_idx = inval_addr[TSB-1:OFFSET_W];

  assign flushing  = (state_q == S_FLUSH);
  assign busy      = flushing;
  assign req_ready = (state_q == S_IDLE) && !fill_en && !inval_en;
  assign req_fire  = req_valid && req_ready;
  assign fill_wr   = fill_en && (state_q == S_IDLE);
  assign inval_wr  = inval_en && !fill_en && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (flush_req) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      end
      default: begin
        if (flush_req) begin
          cnt_d = '0;
        end else if (cnt_q == {INDEX_W{1'b1}}) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge main_clk or posedge main_reset) begin
    if (main_reset) begin
      state_q <= S_FLUSH;
      cnt_q   <= '0;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_p1  <= req_fire;
    end
  end

  // ---- p0 -> p1: capture request, read every way's tag RAM ----
  always_ff @(posedge main_clk) begin
    if (req_fire) begin
      tag_p1 <= req_tag;
      idx_p1 <= req_idx;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [TAG_W-1:0] mem [SETS];
    logic [TAG_W-1:0] rd_p1;
    always_ff @(posedge main_clk) begin
      if (fill_wr && fill_way == WAYW'(w)) mem[fill_idx] <= fill_tag;
      if (req_fire) rd_p1 <= mem[req_idx];
    end
    assign tag_rd_p1[w] = rd_p1;
  end

  // ---- p1: compare, pick hit/victim way ----
  always_comb begin
    vset    = valid_q[idx_p1];
    pset    = plru_q[idx_p1];
    hit     = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    sel_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (vset[w] && tag_rd_p1[w] == tag_p1) begin
        hit     = 1'b1;
        hit_way = WAYW'(w);
      end
      if (!vset[w]) begin
        inv_any = 1'b1;
        inv_way = WAYW'(w);
      end
    end
    if (hit)          sel_way = hit_way;
    else if (inv_any) sel_way = inv_way;
    else              sel_way = plru_victim(pset);
  end

  assign rsp_valid        = vld_p1;
  assign rsp_hit          = vld_p1 && hit;
  assign rsp_way          = vld_p1 ? sel_way : '0;
  assign rsp_victim_valid = vld_p1 && !hit && !inv_any;
  assign rsp_victim_tag   = vld_p1 ? tag_rd_p1[sel_way] : '0;

  // A fill landing on the set just hit must keep the hit's MRU marking too.
  assign hit_upd   = vld_p1 && hit;
  assign fill_base = (hit_upd && idx_p1 == fill_idx) ? plru_touch(pset, hit_way)
                                                     : plru_q[fill_idx];

  always_ff @(posedge main_clk) begin
    if (hit_upd) plru_q[idx_p1] <= plru_touch(pset, hit_way);
    if (fill_wr) begin
      valid_q[fill_idx][fill_way] <= 1'b1;
      plru_q[fill_idx]            <= plru_touch(fill_base, fill_way);
    end else if (inval_wr) begin
      valid_q[inval_idx][inval_way] <= 1'b0;
    end
    if (flushing) begin
      valid_q[cnt_q] <= '0;
      plru_q[cnt_q]  <= '0;
    end
  end
endmodule

// File: tb/tb_cache_tag_array.sv
// Randomized bench for cache_tag_array against a set-level reference model
// (tags, valid flags, half-tree recency) plus directed scenarios.
module tb_cache_tag_array;
  localparam int WAYS = 4, ADDR_W = 26, INDEX_W = 9, OFFSET_W = 4;
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WAYW = 2;
  localparam int SETS = 1 << INDEX_W;

  logic              main_clk = 1'b0, main_reset = 1'b1;
  logic              flush_req = 0, req_valid = 0, fill_en = 0, inval_en = 0;
  logic [ADDR_W-1:0] req_addr = '0, fill_addr = '0, inval_addr = '0;
  logic [WAYW-1:0]   fill_way = '0, inval_way = '0;
  logic              req_ready, rsp_valid, rsp_hit, rsp_victim_valid, busy;
  logic [WAYW-1:0]   rsp_way;
  logic [TAG_W-1:0]  rsp_victim_tag;

  cache_tag_array #(.WAYS(WAYS), .ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W)) dut (
    .main_clk(main_clk), .main_reset(main_reset), .flush_req(flush_req),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .rsp_victim_valid(rsp_victim_valid), .rsp_victim_tag(rsp_victim_tag),
    .fill_en(fill_en), .fill_addr(fill_addr), .fill_way(fill_way),
    .inval_en(inval_en), .inval_addr(inval_addr), .inval_way(inval_way),
    .busy(busy));

  always #5 main_clk = ~main_clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // Reference model state
  bit [TAG_W-1:0] m_tag [SETS][WAYS];
  bit             m_vld [SETS][WAYS];
  bit             m_left_mru [SETS][WAYS-1];
  int             busy_left = SETS;
  bit             pend_vld = 0, pend_hit = 0, pend_vv = 0;
  int             pend_way = 0, pend_set = 0;
  bit [TAG_W-1:0] pend_vtag = '0;

  function automatic int idx_of(input logic [ADDR_W-1:0] a);
    return int'(a[INDEX_W+OFFSET_W-1:OFFSET_W]);
  endfunction
  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:INDEX_W+OFFSET_W];
  endfunction
  function automatic logic [ADDR_W-1:0] mk(input int tag, input int set);
    return ADDR_W'((tag << (INDEX_W + OFFSET_W)) | (set << OFFSET_W) | int'($urandom_range(0, 15)));
  endfunction

  // Walk halving ranges; each node remembers whether its left half was used last.
  task automatic m_touch(input int s, input int w);
    int lo, size, node, half;
    bit right;
    lo = 0; size = WAYS; node = 0;
    while (size > 1) begin
      half = size / 2;
      right = (w >= lo + half);
      m_left_mru[s][node] = !right;
      node = 2 * node + 1 + (right ? 1 : 0);
      if (right) lo += half;
      size = half;
    end
  endtask

  function automatic int m_victim(input int s);
    int lo, size, node, half;
    bit right;
    lo = 0; size = WAYS; node = 0;
    while (size > 1) begin
      half = size / 2;
      right = m_left_mru[s][node];
      node = 2 * node + 1 + (right ? 1 : 0);
      if (right) lo += half;
      size = half;
    end
    return lo;
  endfunction

  task automatic clear_all();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) m_vld[s][w] = 0;
      for (int n = 0; n < WAYS - 1; n++) m_left_mru[s][n] = 0;
    end
  endtask

  task automatic model_edge(input bit acc);
    int s, free;
    logic [TAG_W-1:0] t;
    if (pend_vld && pend_hit) m_touch(pend_set, pend_way);
    if (busy_left == 0) begin
      if (fill_en) begin
        s = idx_of(fill_addr);
        m_tag[s][int'(fill_way)] = tag_of(fill_addr);
        m_vld[s][int'(fill_way)] = 1;
        m_touch(s, int'(fill_way));
      end else if (inval_en) begin
        m_vld[idx_of(inval_addr)][int'(inval_way)] = 0;
      end
      if (flush_req) busy_left = SETS;
    end else if (flush_req) begin
      busy_left = SETS;
    end else begin
      busy_left--;
      if (busy_left == 0) clear_all();
    end
    pend_vld = acc;
    if (acc) begin
      s = idx_of(req_addr);
      t = tag_of(req_addr);
      pend_set = s; pend_hit = 0; pend_vv = 0; pend_way = 0;
      for (int w = 0; w < WAYS; w++)
        if (!pend_hit && m_vld[s][w] && m_tag[s][w] == t) begin
          pend_hit = 1; pend_way = w;
        end
      if (!pend_hit) begin
        free = -1;
        for (int w = 0; w < WAYS; w++) if (free < 0 && !m_vld[s][w]) free = w;
        if (free >= 0) pend_way = free;
        else begin
          pend_way  = m_victim(s);
          pend_vv   = 1;
          pend_vtag = m_tag[s][pend_way];
        end
      end
    end
  endtask

  // One clock: check control outputs, advance model at the edge, check the response.
  task automatic tick();
    bit exp_ready, acc;
    #1;
    exp_ready = (busy_left == 0) && !fill_en && !inval_en;
    chk("busy", busy, busy_left != 0);
    chk("req_ready", req_ready, exp_ready);
    acc = req_valid && exp_ready;
    @(posedge main_clk);
    model_edge(acc);
    #1;
    chk("rsp_valid", rsp_valid, pend_vld);
    if (pend_vld) begin
      chk("rsp_hit", rsp_hit, pend_hit);
      chk("rsp_way", rsp_way, pend_way);
      if (!pend_hit) chk("rsp_victim_valid", rsp_victim_valid, pend_vv);
      if (!pend_hit && pend_vv) chk("rsp_victim_tag", rsp_victim_tag, pend_vtag);
    end
  endtask

  task automatic op_lookup(input logic [ADDR_W-1:0] a);
    req_valid = 1; req_addr = a; tick(); req_valid = 0;
  endtask
  task automatic op_fill(input logic [ADDR_W-1:0] a, input int w);
    fill_en = 1; fill_addr = a; fill_way = WAYW'(w); tick(); fill_en = 0;
  endtask
  task automatic op_inval(input logic [ADDR_W-1:0] a, input int w);
    inval_en = 1; inval_addr = a; inval_way = WAYW'(w); tick(); inval_en = 0;
  endtask
  task automatic wait_flush(input string tag);
    int bc = 0;
    for (int i = 0; i < 600 && busy; i++) begin tick(); bc++; end
    chk(tag, bc, SETS);
  endtask

  logic [ADDR_W-1:0] a18;
  int r, rs, rw;

  initial begin
    repeat (3) @(posedge main_clk);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rsp_way", rsp_way, 0);
    chk("rst_victim_valid", rsp_victim_valid, 0);
    chk("rst_victim_tag", rsp_victim_tag, 0);
    main_reset = 0;
    busy_left = SETS;
    wait_flush("reset_busy_cycles");

    op_lookup(26'h0000010);
    chk("r17_hit", rsp_hit, 0);
    chk("r17_way", rsp_way, 0);
    chk("r17_vv", rsp_victim_valid, 0);

    a18 = {13'h1A5, 9'd1, 4'd0};
    op_fill(a18, 2);
    op_lookup(a18);
    chk("r18_hit", rsp_hit, 1);
    chk("r18_way", rsp_way, 2);

    for (int w = 0; w < WAYS; w++) op_fill(mk(16 + w, 5), w);
    op_lookup(mk(32, 5));
    chk("r19_miss_way", rsp_way, 0);
    chk("r19_miss_vv", rsp_victim_valid, 1);
    chk("r19_miss_vtag", rsp_victim_tag, 16);
    op_lookup(mk(16, 5));
    chk("r19_hit0", rsp_hit, 1);
    chk("r19_hit0_way", rsp_way, 0);
    op_lookup(mk(33, 5));
    chk("r19_miss2_hit", rsp_hit, 0);
    chk("r19_miss2_way", rsp_way, 2);

    op_inval(mk(0, 5), 1);
    op_lookup(mk(34, 5));
    chk("r20_way", rsp_way, 1);
    chk("r20_vv", rsp_victim_valid, 0);

    fill_en = 1; fill_addr = mk(51, 7); fill_way = 3;
    req_valid = 1; req_addr = mk(51, 7);
    #1 chk("r22_ready", req_ready, 0);
    tick();
    fill_en = 0;
    tick();
    req_valid = 0;
    chk("r22_hit", rsp_hit, 1);
    chk("r22_way", rsp_way, 3);

    flush_req = 1; tick(); flush_req = 0;
    wait_flush("flush_busy_cycles");
    op_lookup(a18);
    chk("r21_a18_miss", rsp_hit, 0);
    op_lookup(mk(51, 7));
    chk("r21_set7_miss", rsp_hit, 0);

    for (int i = 0; i < 2500; i++) begin
      r  = $urandom_range(0, 99);
      rs = ($urandom_range(0, 4) == 4) ? SETS - 1 : int'($urandom_range(0, 3));
      rw = int'($urandom_range(0, WAYS - 1));
      flush_req = ($urandom_range(0, 999) == 0);
      if (r < 40 || (r >= 70 && r < 76)) begin req_valid = 1; req_addr = mk($urandom_range(0, 5), rs); end
      if (r >= 40 && r < 62 || r >= 70 && r < 80) begin fill_en = 1; fill_addr = mk($urandom_range(0, 5), rs); fill_way = WAYW'(rw); end
      if (r >= 62 && r < 70 || r >= 76 && r < 80) begin inval_en = 1; inval_addr = mk(0, rs); inval_way = WAYW'($urandom_range(0, WAYS - 1)); end
      tick();
      req_valid = 0; fill_en = 0; inval_en = 0; flush_req = 0;
    end
    for (int i = 0; i < 600 && busy_left != 0; i++) tick();

    op_fill(mk(3, 9), 1);
    req_valid = 1; req_addr = mk(3, 9);
    #1;
    @(posedge main_clk);
    #1 main_reset = 1;
    req_valid = 0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_hit", rsp_hit, 0);
    chk("midrst_busy", busy, 1);
    @(posedge main_clk);
    #1;
    chk("midrst_rsp_valid2", rsp_valid, 0);
    main_reset = 0;
    pend_vld = 0;
    busy_left = SETS;
    wait_flush("midrst_busy_cycles");
    op_lookup(mk(3, 9));
    chk("post_rst_miss", rsp_hit, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cache_tag_array.md
CACHE_TAG_ARRAY -- requirements
Module: cache_tag_array

Interface
REQ-001 Parameters SHALL be: WAYS, default 4, number of ways (power of two, 2..8); ADDR_W, default 26, address width; INDEX_W, default 9, set index width; OFFSET_W, default 4, line offset width; TAG_W = ADDR_W-INDEX_W-OFFSET_W (derived).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  main_clk  input  1  sole clock, all state on rising edge
  main_reset  input  1  asynchronous, active-high reset
  flush_req  input  1  pulse: invalidate all sets
  req_valid  input  1  lookup request
  req_ready  output  1  lookup accepted when req_valid&&req_ready
  req_addr  input  ADDR_W  lookup address
  rsp_valid  output  1  lookup result valid (one cycle)
  rsp_hit  output  1  tag matched a valid way
  rsp_way  output  log2(WAYS)  hit way on hit, victim way on miss
  rsp_victim_valid  output  1  victim way holds a valid line
  rsp_victim_tag  output  TAG_W  tag stored in victim way
  fill_en  input  1  write tag into fill_way of set of fill_addr
  fill_addr  input  ADDR_W  fill address
  fill_way  input  log2(WAYS)  way to write
  inval_en  input  1  clear valid of inval_way in set of inval_addr
  inval_addr  input  ADDR_W  invalidate address
  inval_way  input  log2(WAYS)  way to invalidate
  busy  output  1  flush in progress

Function
REQ-003 Address split SHALL be tag=addr[ADDR_W-1:INDEX_W+OFFSET_W], index=addr[INDEX_W+OFFSET_W-1:OFFSET_W].
REQ-004 Storage SHALL be per-way tag RAM (synchronous read, 1-cycle), plus per-set per-way valid bits and per-set tree-PLRU bits (WAYS-1) in registers or RAM.
REQ-005 State machine SHALL have states FLUSH and IDLE; reset enters FLUSH with counter 0.
REQ-006 FLUSH SHALL clear valid and PLRU bits of one set per cycle, index 0 to 2^INDEX_W-1, then enter IDLE; busy=1 and req_ready=0 throughout FLUSH.
REQ-007 flush_req in IDLE SHALL enter FLUSH next cycle with counter 0; flush_req during FLUSH SHALL restart the counter at 0; a lookup in flight completes normally.
REQ-008 req_ready SHALL be 1 only in IDLE with fill_en=0 and inval_en=0 (fill/invalidate have priority).
REQ-009 Lookup accepted in cycle N SHALL give rsp_valid=1 in cycle N+1 only, with results for the set state including every fill/invalidate committed up to and including cycle N (bypass required; stale RAM output forbidden).
REQ-010 Hit: rsp_hit=1, rsp_way=matching valid way; multiple matches SHALL report the lowest index; PLRU of that set SHALL be updated to mark the way most-recently-used at the end of cycle N+1.
REQ-011 Miss: rsp_way SHALL be the lowest-index invalid way if any (rsp_victim_valid=0), else the PLRU-selected way (rsp_victim_valid=1); rsp_victim_tag SHALL be the stored tag of rsp_way; PLRU unchanged on miss.
REQ-012 Fill in IDLE SHALL write tag, set valid, and mark fill_way MRU in one cycle; inval_en in IDLE SHALL clear one valid bit, PLRU unchanged; fill_en and inval_en together SHALL execute fill only.
REQ-013 fill_en/inval_en during FLUSH SHALL be ignored.
REQ-014 rsp_* other than rsp_valid SHALL be don't-care when rsp_valid=0 but SHALL not be X after reset.

Reset
REQ-015 On main_reset=1, asynchronously: state=FLUSH, counter=0, busy=1, req_ready=0, rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_victim_valid=0, rsp_victim_tag=0; a lookup in flight SHALL be discarded.
REQ-016 After release, busy SHALL fall exactly 2^INDEX_W cycles later; tag RAM contents need not be cleared.

Verification (WAYS=4 defaults)
REQ-017 Reset release -> busy=1 for 512 cycles, then req_ready=1; lookup 0x0000010 -> rsp_hit=0, rsp_way=0, rsp_victim_valid=0.
REQ-018 Fill set 1 way 2 tag 0x1A5, lookup same address next cycle -> rsp_hit=1, rsp_way=2.
REQ-019 Fill ways 0..3 of set 5 in order, lookup miss to set 5 -> rsp_way=0, rsp_victim_valid=1, victim tag = way 0 tag; hit way 0, then miss -> rsp_way=2.
REQ-020 Invalidate way 1 of full set 5, miss lookup -> rsp_way=1, rsp_victim_valid=0.
REQ-021 flush_req after fills -> busy 512 cycles, all prior lookups miss; main_reset asserted mid-lookup -> rsp_valid stays 0.
REQ-022 fill_en and req_valid same cycle -> req_ready=0, fill committed, lookup accepted next cycle sees it.
